// File: rtl/cnn1d_feeder.sv
// cnn1d_feeder: buffers an upstream sample stream in a show-ahead FIFO,
// feeds exactly FRAME_LEN samples per frame into a cnn1d core, collects the
// core's WORN/OK result and publishes one report per frame with a wrapping
// frame id.
// Optional feature: define CNN1D_FEEDER_TIMEOUT_EN to bound the result wait
// to TIMEOUT_CYCLES; on expiry a report with out_timeout=1 is produced.
module cnn1d_feeder #(
    parameter int DATA_WIDTH     = 32,
    parameter int FRAME_LEN      = 260,
    parameter int FIFO_DEPTH     = 16,
    parameter int FRAME_ID_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      src_valid,
    output logic                      src_ready,
    input  logic [DATA_WIDTH-1:0]     src_data,
    output logic                      feed_valid,
    input  logic                      feed_ready,
    output logic [DATA_WIDTH-1:0]     feed_data,
    input  logic                      res_valid,
    input  logic                      res_condition,
    output logic                      res_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_condition,
    output logic [FRAME_ID_WIDTH-1:0] out_frame_id,
    output logic                      out_timeout,
    output logic                      busy
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int SCW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_REPORT   = 2'd3
    } state_e;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  src_ready_q;
    logic                  wr_en_s;
    logic                  rd_en_s;

    // Frame control
    state_e                    state_q;
    logic [SCW-1:0]            sample_cnt_q;
    logic                      feed_valid_q;
    logic                      res_ready_q;
    logic                      out_valid_q;
    logic                      out_condition_q;
    logic [FRAME_ID_WIDTH-1:0] out_frame_id_q;
    logic                      busy_q;

`ifdef CNN1D_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q;
    logic          out_timeout_q;
`endif

    // Handshake qualifiers and next FIFO occupancy
    always_comb begin
        wr_en_s = src_valid && src_ready_q;
        rd_en_s = feed_valid_q && feed_ready;
        count_d = count_q;
        if (wr_en_s && !rd_en_s) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en_s && rd_en_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Sample storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= src_data;
        end
    end

    // FIFO pointers, occupancy and registered not-full flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= AW'(0);
            rd_ptr_q    <= AW'(0);
            count_q     <= CW'(0);
            src_ready_q <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q     <= count_d;
            src_ready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

    // Frame sequencer with registered handshake and report outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            sample_cnt_q    <= SCW'(0);
            feed_valid_q    <= 1'b0;
            res_ready_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_condition_q <= 1'b0;
            out_frame_id_q  <= FRAME_ID_WIDTH'(0);
            busy_q          <= 1'b0;
`ifdef CNN1D_FEEDER_TIMEOUT_EN
            timer_q         <= TW'(0);
            out_timeout_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != CW'(0)) begin
                        // No reads happen in IDLE, so the FIFO stays non-empty.
                        state_q      <= ST_STREAM;
                        sample_cnt_q <= SCW'(0);
                        feed_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (rd_en_s && (sample_cnt_q == SCW'(FRAME_LEN - 1))) begin
                        state_q      <= ST_WAIT_RES;
                        sample_cnt_q <= SCW'(0);
                        feed_valid_q <= 1'b0;
                        res_ready_q  <= 1'b1;
`ifdef CNN1D_FEEDER_TIMEOUT_EN
                        timer_q      <= TW'(0);
`endif
                    end else if (rd_en_s) begin
                        sample_cnt_q <= sample_cnt_q + SCW'(1);
                        feed_valid_q <= (count_d != CW'(0));
                    end else begin
                        // Without a read occupancy cannot fall, so a raised
                        // feed_valid holds until its handshake.
                        feed_valid_q <= (count_d != CW'(0));
                    end
                end
                ST_WAIT_RES: begin
                    if (res_valid) begin
                        state_q         <= ST_REPORT;
                        res_ready_q     <= 1'b0;
                        out_valid_q     <= 1'b1;
                        out_condition_q <= res_condition;
`ifdef CNN1D_FEEDER_TIMEOUT_EN
                        out_timeout_q   <= 1'b0;
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q         <= ST_REPORT;
                        res_ready_q     <= 1'b0;
                        out_valid_q     <= 1'b1;
                        out_condition_q <= 1'b0;
                        out_timeout_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
`else
                    end else begin
                        state_q <= ST_WAIT_RES;
                    end
`endif
                end
                ST_REPORT: begin
                    if (out_ready) begin
                        state_q        <= ST_IDLE;
                        out_valid_q    <= 1'b0;
                        busy_q         <= 1'b0;
                        out_frame_id_q <= out_frame_id_q + FRAME_ID_WIDTH'(1);
                    end else begin
                        state_q <= ST_REPORT;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    feed_valid_q <= 1'b0;
                    res_ready_q  <= 1'b0;
                    out_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign src_ready     = src_ready_q;
    assign feed_valid    = feed_valid_q;
    assign feed_data     = mem_q[rd_ptr_q];
    assign res_ready     = res_ready_q;
    assign out_valid     = out_valid_q;
    assign out_condition = out_condition_q;
    assign out_frame_id  = out_frame_id_q;
    assign busy          = busy_q;
`ifdef CNN1D_FEEDER_TIMEOUT_EN
    assign out_timeout   = out_timeout_q;
`else
    assign out_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cnn1d_feeder.sv
// Scoreboard bench for cnn1d_feeder (FRAME_LEN=4, FIFO_DEPTH=4,
// TIMEOUT_CYCLES=8). Expected feed data and reports are queued when the
// stimulus is issued; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_cnn1d_feeder;

    localparam int DW  = 32;
    localparam int FL  = 4;
    localparam int FD  = 4;
    localparam int FIW = 8;
    localparam int TO  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           src_valid = 1'b0;
    logic           src_ready;
    logic [DW-1:0]  src_data = '0;
    logic           feed_valid;
    logic           feed_ready = 1'b0;
    logic [DW-1:0]  feed_data;
    logic           res_valid = 1'b0;
    logic           res_condition = 1'b0;
    logic           res_ready;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           out_condition;
    logic [FIW-1:0] out_frame_id;
    logic           out_timeout;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int hs_count = 0;
    int mode     = 1;   // feed_ready: 0 low, 1 high, 2 toggle
    logic [DW-1:0] feed_exp [$];
    logic [9:0]    rep_exp  [$];   // {timeout, condition, frame_id}
    logic [FIW-1:0] exp_id = '0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    cnn1d_feeder #(
        .DATA_WIDTH(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD),
        .FRAME_ID_WIDTH(FIW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .feed_valid(feed_valid), .feed_ready(feed_ready), .feed_data(feed_data),
        .res_valid(res_valid), .res_condition(res_condition), .res_ready(res_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_condition(out_condition),
        .out_frame_id(out_frame_id), .out_timeout(out_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // feed_ready pattern generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: feed_ready = 1'b0;
                1: feed_ready = 1'b1;
                2: feed_ready = ~feed_ready;
                default: feed_ready = 1'b0;
            endcase
        end
    end

    // Monitor: feed scoreboard, stall stability, report scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev) begin
                check("feed_valid_held", feed_valid, 1);
                check("feed_data_held", feed_data, prev_data);
            end
            stall_prev = feed_valid && !feed_ready;
            prev_data  = feed_data;
            if (feed_valid && feed_ready) begin
                hs_count++;
                if (feed_exp.size() == 0) begin
                    check("feed_unexpected", feed_valid, 0);
                end else begin
                    check("feed_data", feed_data, feed_exp.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                if (rep_exp.size() == 0) begin
                    check("report_unexpected", out_valid, 0);
                end else begin
                    logic [9:0] e;
                    e = rep_exp.pop_front();
                    check("out_timeout", out_timeout, e[9]);
                    check("out_condition", out_condition, e[8]);
                    check("out_frame_id", out_frame_id, e[7:0]);
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push(input logic [DW-1:0] d);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        src_valid = 1'b1;
        src_data  = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = src_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("push_accepted", acc, 1);
        if (acc) feed_exp.push_back(d);
        src_valid = 1'b0;
    endtask

    task automatic wait_res_ready;
        int n;
        n = 0;
        while (!res_ready && n < 100) begin
            tick;
            n++;
        end
        check("wait_res_ready", res_ready, 1);
    endtask

    task automatic expect_rep(input logic to, input logic cond);
        rep_exp.push_back({to, cond, exp_id});
        exp_id = exp_id + 8'd1;
    endtask

    task automatic pulse_res(input logic cond);
        res_valid = 1'b1;
        res_condition = cond;
        tick;
        res_valid = 1'b0;
        res_condition = 1'b0;
    endtask

    task automatic wait_rep_done;
        int n;
        n = 0;
        while (rep_exp.size() != 0 && n < 100) begin
            tick;
            n++;
        end
        check("report_seen", rep_exp.size(), 0);
    endtask

    task automatic frame(input logic [DW-1:0] base, input logic cond, input int dly);
        for (int i = 0; i < FL; i++) push(base + DW'(i));
        wait_res_ready;
        repeat (dly) tick;
        expect_rep(1'b0, cond);
        pulse_res(cond);
        wait_rep_done;
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_base;
        int n;
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_src_ready", src_ready, 0);
        check("rst_feed_valid", feed_valid, 0);
        check("rst_res_ready", res_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_condition", out_condition, 0);
        check("rst_out_timeout", out_timeout, 0);
        check("rst_out_frame_id", out_frame_id, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        tick;
        check("src_ready_after_release", src_ready, 1);

        // Basic frame: 1,2,3,4 then WORN two cycles into WAIT_RES
        frame(32'd1, 1'b1, 2);

        // Backpressure: feed stalled, FIFO fills, extra samples wait upstream
        mode = 0;
        repeat (2) tick;
        for (int i = 0; i < 4; i++) push(32'hA0 + DW'(i));
        check("full_src_ready", src_ready, 0);
        fork
            begin
                push(32'hA4);
                push(32'hA5);
            end
            begin
                repeat (3) begin
                    tick;
                    check("full_hold_src_ready", src_ready, 0);
                    check("stall_feed_valid", feed_valid, 1);
                    check("stall_feed_head", feed_data, 32'hA0);
                end
                mode = 1;
            end
        join
        wait_res_ready;
        check("wait_res_busy", busy, 1);
        check("wait_res_feed_valid", feed_valid, 0);

        // Toggling feed_ready: exactly FRAME_LEN handshakes to WAIT_RES
        hs_base = hs_count;
        mode = 2;
        expect_rep(1'b0, 1'b1);
        pulse_res(1'b1);
        wait_rep_done;
        push(32'hA6);
        push(32'hA7);
        wait_res_ready;
        check("toggle_handshakes", hs_count - hs_base, 4);
        mode = 1;
        expect_rep(1'b0, 1'b0);
        pulse_res(1'b0);
        wait_rep_done;

        // res_valid during STREAM is ignored
        mode = 0;
        repeat (2) tick;
        for (int i = 0; i < 4; i++) push(32'hC0 + DW'(i));
        res_valid = 1'b1;
        res_condition = 1'b1;
        repeat (2) begin
            tick;
            check("stream_res_ready", res_ready, 0);
            check("stream_out_valid", out_valid, 0);
        end
        res_valid = 1'b0;
        res_condition = 1'b0;
        mode = 1;
        wait_res_ready;
        expect_rep(1'b0, 1'b0);
        pulse_res(1'b0);
        wait_rep_done;

        // Result wait limit
        for (int i = 0; i < 4; i++) push(32'hD0 + DW'(i));
        wait_res_ready;
`ifdef CNN1D_FEEDER_TIMEOUT_EN
        expect_rep(1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            tick;
            n++;
        end
        check("timeout_latency", n, 8);
        wait_rep_done;
`else
        repeat (20) tick;
        check("no_timeout_out_valid", out_valid, 0);
        check("no_timeout_res_ready", res_ready, 1);
        expect_rep(1'b0, 1'b0);
        pulse_res(1'b0);
        wait_rep_done;
`endif

        // Reset after two of four samples fed
        hs_base = hs_count;
        push(32'h51);
        push(32'h52);
        n = 0;
        while (hs_count < hs_base + 2 && n < 50) begin
            tick;
            n++;
        end
        tick;
        check("mid_frame_handshakes", hs_count - hs_base, 2);
        check("mid_frame_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_feed_valid", feed_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_res_ready", res_ready, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_src_ready", src_ready, 0);
        check("async_rst_out_frame_id", out_frame_id, 0);
        feed_exp.delete();
        exp_id = '0;
        repeat (2) tick;
        rst = 1'b1;
        tick;
        check("src_ready_after_mid_rst", src_ready, 1);
        frame(32'hE0, 1'b1, 0);

        // Back-to-back frames across the 8-bit frame id wrap
        for (int f = 1; f < 258; f++) begin
            frame(DW'(f) << 8, f[0], 0);
        end
        check("frame_id_wrapped", out_frame_id, 8'd2);

        check("feed_queue_drained", feed_exp.size(), 0);
        check("report_queue_drained", rep_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
